// File: rtl/stream_max_reduce_if.sv
// Sample-in / result-out handshake bundle for stream_max_reduce.
// STREAM_MAX_REDUCE_MIN_EN adds the window-minimum result fields.
interface stream_max_reduce_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WIN_LEN    = 4
);
  localparam int unsigned IW = ($clog2(WIN_LEN) < 1) ? 1 : $clog2(WIN_LEN);

  logic                  client_val;
  logic [DATA_WIDTH-1:0] client_data;
  logic                  client_last;
  logic                  client_rdy;
  logic                  max_val;
  logic                  max_rdy;
  logic [DATA_WIDTH-1:0] max_data;
  logic [IW-1:0]         max_idx;
  logic [IW:0]           max_cnt;
`ifdef STREAM_MAX_REDUCE_MIN_EN
  logic [DATA_WIDTH-1:0] min_data;
  logic [IW-1:0]         min_idx;

  modport slave (
    input  client_val, client_data, client_last, max_rdy,
    output client_rdy, max_val, max_data, max_idx, max_cnt, min_data, min_idx
  );
  modport master (
    output client_val, client_data, client_last, max_rdy,
    input  client_rdy, max_val, max_data, max_idx, max_cnt, min_data, min_idx
  );
`else
  modport slave (
    input  client_val, client_data, client_last, max_rdy,
    output client_rdy, max_val, max_data, max_idx, max_cnt
  );
  modport master (
    output client_val, client_data, client_last, max_rdy,
    input  client_rdy, max_val, max_data, max_idx, max_cnt
  );
`endif
endinterface

// File: rtl/stream_max_reduce.sv
// Per-window maximum (and optionally minimum, STREAM_MAX_REDUCE_MIN_EN) of a sample stream,
// with a single-entry registered result and early window close via client_last.
module stream_max_reduce #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WIN_LEN    = 4,
  parameter int unsigned SIGNED_CMP = 0
) (
  input  logic               clk,
  input  logic               rst,
  stream_max_reduce_if.slave bus
);
  localparam int unsigned IW       = ($clog2(WIN_LEN) < 1) ? 1 : $clog2(WIN_LEN);
  localparam int unsigned CW       = IW + 1;
  localparam int unsigned LAST_POS = WIN_LEN - 1;

  logic [IW-1:0]         pos;
  logic [DATA_WIDTH-1:0] run_max;
  logic [IW-1:0]         run_max_idx;
  logic                  out_val;
  logic [DATA_WIDTH-1:0] out_max;
  logic [IW-1:0]         out_max_idx;
  logic [CW-1:0]         out_cnt;

  logic                  closing_c;
  logic                  rdy_c;
  logic                  accept_c;
  logic                  first_c;
  logic                  max_gt_c;
  logic [DATA_WIDTH-1:0] cand_max_c;
  logic [IW-1:0]         cand_max_idx_c;

  // Window-close detection, input backpressure and running-max candidate
  always_comb begin
    closing_c = (pos == IW'(LAST_POS)) || bus.client_last;
    rdy_c     = !(closing_c && out_val && !bus.max_rdy);
    accept_c  = bus.client_val && rdy_c;
    first_c   = (pos == '0);
    if (SIGNED_CMP != 0) max_gt_c = $signed(bus.client_data) > $signed(run_max);
    else                 max_gt_c = bus.client_data > run_max;
    cand_max_c     = (first_c || max_gt_c) ? bus.client_data : run_max;
    cand_max_idx_c = (first_c || max_gt_c) ? pos : run_max_idx;
  end

  // Window accumulation and result register; the result only reloads when it is free or leaving
  always_ff @(posedge clk) begin
    if (rst) begin
      pos         <= '0;
      run_max     <= '0;
      run_max_idx <= '0;
      out_val     <= 1'b0;
      out_max     <= '0;
      out_max_idx <= '0;
      out_cnt     <= '0;
    end else begin
      if (out_val && bus.max_rdy) out_val <= 1'b0;
      if (accept_c) begin
        if (closing_c) begin
          out_val     <= 1'b1;
          out_max     <= cand_max_c;
          out_max_idx <= cand_max_idx_c;
          out_cnt     <= CW'(pos) + CW'(1);
          pos         <= '0;
        end else begin
          run_max     <= cand_max_c;
          run_max_idx <= cand_max_idx_c;
          pos         <= pos + IW'(1);
        end
      end
    end
  end

  assign bus.client_rdy = rdy_c;
  assign bus.max_val    = out_val;
  assign bus.max_data   = out_max;
  assign bus.max_idx    = out_max_idx;
  assign bus.max_cnt    = out_cnt;

`ifdef STREAM_MAX_REDUCE_MIN_EN
  logic [DATA_WIDTH-1:0] run_min;
  logic [IW-1:0]         run_min_idx;
  logic [DATA_WIDTH-1:0] out_min;
  logic [IW-1:0]         out_min_idx;
  logic                  min_lt_c;
  logic [DATA_WIDTH-1:0] cand_min_c;
  logic [IW-1:0]         cand_min_idx_c;

  // Running-min candidate, mirroring the max path with the comparison reversed
  always_comb begin
    if (SIGNED_CMP != 0) min_lt_c = $signed(bus.client_data) < $signed(run_min);
    else                 min_lt_c = bus.client_data < run_min;
    cand_min_c     = (first_c || min_lt_c) ? bus.client_data : run_min;
    cand_min_idx_c = (first_c || min_lt_c) ? pos : run_min_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_min     <= '0;
      run_min_idx <= '0;
      out_min     <= '0;
      out_min_idx <= '0;
    end else if (accept_c) begin
      if (closing_c) begin
        out_min     <= cand_min_c;
        out_min_idx <= cand_min_idx_c;
      end else begin
        run_min     <= cand_min_c;
        run_min_idx <= cand_min_idx_c;
      end
    end
  end

  assign bus.min_data = out_min;
  assign bus.min_idx  = out_min_idx;
`endif
endmodule
